// File: rtl/seq_alu_pkg.sv
// Shared opcode/state encodings and default width for the sequential ALU.
// SEQ_ALU_DIV_EN adds the DIV state to the state enum.
package seq_alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned FUNC_W       = 5;

    typedef enum logic [FUNC_W-1:0] {
        FN_ADD      = 5'd0,
        FN_SUB      = 5'd1,
        FN_SLL      = 5'd2,
        FN_SLT      = 5'd3,
        FN_SLTU     = 5'd4,
        FN_XOR      = 5'd5,
        FN_SRL      = 5'd6,
        FN_SRA      = 5'd7,
        FN_OR       = 5'd8,
        FN_AND      = 5'd9,
        FN_ADD_JALR = 5'd10,
        FN_MUL      = 5'd11,
        FN_MULH     = 5'd12,
        FN_MULHU    = 5'd13,
        FN_DIV      = 5'd14,
        FN_DIVU     = 5'd15,
        FN_REM      = 5'd16,
        FN_REMU     = 5'd17
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef SEQ_ALU_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_mul(input logic [FUNC_W-1:0] f);
        return (f == FN_MUL) || (f == FN_MULH) || (f == FN_MULHU);
    endfunction

    function automatic logic is_div(input logic [FUNC_W-1:0] f);
        return (f == FN_DIV) || (f == FN_DIVU) || (f == FN_REM) || (f == FN_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [FUNC_W-1:0] f);
        return (f == FN_DIV) || (f == FN_REM);
    endfunction

    function automatic logic is_quot(input logic [FUNC_W-1:0] f);
        return (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs re-applied on the final values so the result is ready on the last iteration.
module seq_alu_div
    import seq_alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            signed_op,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CW = $clog2(XLEN);

    logic            active_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [XLEN-1:0] quo_n, rem_n;
    logic [XLEN:0]   rem_sh, diff;
    logic            neg_quo_q, neg_rem_q;
    logic            a_neg, b_neg;

    assign a_neg = signed_op && a[XLEN-1];
    assign b_neg = signed_op && b[XLEN-1];

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        rem_n  = rem_sh[XLEN-1:0];
        quo_n  = {quo_q[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_n = diff[XLEN-1:0];
            quo_n = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (start) begin
            active_q  <= 1'b1;
            cnt_q     <= '0;
            quo_q     <= a_neg ? -a : a;
            rem_q     <= '0;
            dvs_q     <= b_neg ? -b : b;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end else if (active_q) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

    assign done      = active_q && (cnt_q == CW'(XLEN - 1));
    assign quotient  = neg_quo_q ? -quo_n : quo_n;
    assign remainder = neg_rem_q ? -rem_n : rem_n;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle base ops, XLEN-cycle shift-add multiply and, when
// SEQ_ALU_DIV_EN is defined, XLEN-cycle restoring divide, behind a valid/ready pair.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] func,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              eq,
    output logic              lt,
    output logic              ltu,
    output logic              busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned PW  = 2 * XLEN;

    state_e            state_q, state_d, target;
    logic              accept;
    logic [FUNC_W-1:0] op_q;
    logic [SHW-1:0]    cnt_q;
    logic              mul_last;
    logic [PW-1:0]     acc_q, acc_n, mcand_q, prod;
    logic [XLEN-1:0]   mplier_q, mul_res;
    logic              mul_neg_q;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   sum, simple_res;
    logic [SHW-1:0]    sh;
    logic              eq_c, lt_c, ltu_c;

    assign sh    = b[SHW-1:0];
    assign sum   = a + b;
    assign eq_c  = (a == b);
    assign lt_c  = ($signed(a) < $signed(b));
    assign ltu_c = (a < b);

`ifdef SEQ_ALU_DIV_EN
    logic            div_zero, div_ovf, div_start, div_done;
    logic [XLEN-1:0] div_quo, div_rem;

    assign div_zero  = (b == '0);
    assign div_ovf   = is_signed_div(func) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign div_start = accept && (target == ST_DIV);

    seq_alu_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .a         (a),
        .b         (b),
        .signed_op (is_signed_div(func)),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`endif

    // Single-cycle results, including the divide-by-zero / overflow bypass values.
    always_comb begin
        simple_res = '0;
        case (func)
            FN_ADD:      simple_res = sum;
            FN_SUB:      simple_res = a - b;
            FN_SLL:      simple_res = a << sh;
            FN_SLT:      simple_res = XLEN'(lt_c);
            FN_SLTU:     simple_res = XLEN'(ltu_c);
            FN_XOR:      simple_res = a ^ b;
            FN_SRL:      simple_res = a >> sh;
            FN_SRA:      simple_res = XLEN'($signed(a) >>> sh);
            FN_OR:       simple_res = a | b;
            FN_AND:      simple_res = a & b;
            FN_ADD_JALR: simple_res = {sum[XLEN-1:1], 1'b0};
`ifdef SEQ_ALU_DIV_EN
            FN_DIV, FN_DIVU: simple_res = div_zero ? '1 : a;
            FN_REM, FN_REMU: simple_res = div_zero ? a : '0;
`endif
            default:     simple_res = '0;
        endcase
    end

    // Where an accepted operation goes next.
    always_comb begin
        target = ST_DONE;
        if (is_mul(func)) begin
            target = ST_MUL;
        end
`ifdef SEQ_ALU_DIV_EN
        else if (is_div(func) && !div_zero && !div_ovf) begin
            target = ST_DIV;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        accept   = in_valid && in_ready;
        case (state_q)
            ST_IDLE: if (accept) state_d = target;
            ST_MUL:  if (mul_last) state_d = ST_DONE;
`ifdef SEQ_ALU_DIV_EN
            ST_DIV:  if (div_done) state_d = ST_DONE;
`endif
            ST_DONE: if (out_ready) state_d = accept ? target : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiplier operates on magnitudes only for MULH; the product is negated at the end.
    assign a_mag    = ((func == FN_MULH) && a[XLEN-1]) ? -a : a;
    assign b_mag    = ((func == FN_MULH) && b[XLEN-1]) ? -b : b;
    assign mul_last = (cnt_q == SHW'(XLEN - 1));
    assign acc_n    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod     = mul_neg_q ? -acc_n : acc_n;
    assign mul_res  = (op_q == FN_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            ltu       <= 1'b0;
            op_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mul_neg_q <= 1'b0;
        end else begin
            out_valid <= (state_d == ST_DONE);
            busy      <= (state_d != ST_IDLE);
            if (accept) begin
                op_q  <= func;
                eq    <= eq_c;
                lt    <= lt_c;
                ltu   <= ltu_c;
                cnt_q <= '0;
                if (target == ST_DONE) begin
                    result <= simple_res;
                end
                if (target == ST_MUL) begin
                    acc_q     <= '0;
                    mcand_q   <= {{XLEN{1'b0}}, a_mag};
                    mplier_q  <= b_mag;
                    mul_neg_q <= (func == FN_MULH) && (a[XLEN-1] ^ b[XLEN-1]);
                end
            end
            if (state_q == ST_MUL) begin
                acc_q    <= acc_n;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SHW'(1);
                if (mul_last) begin
                    result <= mul_res;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            if ((state_q == ST_DIV) && div_done) begin
                result <= is_quot(op_q) ? div_quo : div_rem;
            end
`endif
        end
    end

endmodule
